// File: rtl/counter_sched_if.sv
// rtl/counter_sched_if.sv - requester/scheduler bundle for the shared down-counting timer
interface counter_sched_if #(
  parameter int IW = 2,
  parameter int W  = 8
);
  localparam int N = 2 ** IW;

  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [IW-1:0]  owner;
  logic [W-1:0]   count;

  // Requesting engines drive req/len and watch the grant/done lines.
  modport master (
    output req, len,
    input  grant, done, busy, owner, count
  );

  // The scheduler samples requests and owns the timer state.
  modport slave (
    input  req, len,
    output grant, done, busy, owner, count
  );
endinterface

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one down-counting timer among N requesters
module counter_sched #(
  parameter int IW = 2,
  parameter int W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  counter_sched_if.slave   bus
);
  localparam int N = 2 ** IW;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [W-1:0]  count_q, count_d;

  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;
  assign bus.count = count_q;

  // Round-robin pick plus next-state: arbitrate in IDLE/DONE, count down in RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    owner_d = owner_q;
    count_d = count_q;
    found   = 1'b0;
    win     = '0;
    idx     = '0;

    // First requester at or after the pointer wins; index arithmetic wraps mod N.
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + IW'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (found) begin
          state_d      = ST_RUN;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          count_d      = bus.len[win*W +: W];
          busy_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (!bus.req[owner_q]) begin
          // Owner walked away: release silently, no done pulse.
          state_d = ST_IDLE;
          grant_d = '0;
          count_d = '0;
          busy_d  = 1'b0;
          ptr_d   = owner_q + 1'b1;
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          state_d          = ST_DONE;
          grant_d          = '0;
          done_d[owner_q]  = 1'b1;
          ptr_d            = owner_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end
endmodule
